// File: rtl/spi_pkg.sv
// Shared SPI definitions: transmitter state encoding, bus mode and word width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

  // Transmitter phases; every state except IDLE lasts one divider period.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    HOLD = 3'd3,
    GAP  = 3'd4
  } spi_state_e;

  // SPI mode 0: {CPOL, CPHA} = 2'b00. sclk idles at CPOL; data is sampled
  // on the leading (rising) edge.
  localparam logic [1:0] SPI_MODE = 2'b00;
  localparam logic       SPI_CPOL = SPI_MODE[1];

  // Word width shared with the serial-to-parallel receiver.
  localparam int SPI_WORD_BITS = 16;

  // Counter width for a 0..range-1 counter, never narrower than one bit.
  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Phase divider: pulses phase_done on the last cycle of every CLK_DIV-cycle window.
// Latency: first pulse CLK_DIV-1 cycles after a restart edge.
// Backpressure: none; free-running, restart realigns the window.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   restart    clears the divider on the next edge (FSM state change)
//   phase_done high while the divider sits at CLK_DIV-1
module spi_phase_timer
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase_done
);

  localparam int            CW   = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap explicitly at CLK_DIV-1 so non-power-of-two dividers keep exact timing.
  always_comb begin
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_done = (cnt_q == LAST);

endmodule

// File: rtl/spi_word_tx.sv
// SPI mode-0 master transmitter: serialises one DATA_BITS word LSB-first on sclk/mosi/cs_n.
// Latency: in_ready returns 2*DATA_BITS*CLK_DIV + 2*CLK_DIV cycles after the accept edge.
// Backpressure: in_ready is high only in IDLE; in_valid is ignored while busy.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   in_data      word to send, sampled only on the accept edge
//   in_valid     in_data is valid
//   in_ready     block can accept a word (IDLE only)
//   busy         transaction in progress (inverse of in_ready)
//   sclk/mosi    SPI clock (idles low) and serial data, LSB first
//   cs_n         active-low chip select
module spi_word_tx
  import spi_pkg::*;
#(
  parameter int DATA_BITS = SPI_WORD_BITS,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 cs_n
);

  localparam int            BW       = cnt_width(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  spi_state_e           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 cs_n_q, cs_n_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;

  logic accept;
  logic restart;
  logic phase_done;

  assign accept  = in_valid && in_ready_q;
  // Every state change starts a fresh divider window, including the accept
  // out of IDLE where the divider has been free-running.
  assign restart = (state_d != state_q);

  spi_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .phase_done (phase_done)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= SPI_CPOL;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  // Next state, shift register and bit counter.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = LOW;
          shift_d   = in_data;
          bit_cnt_d = '0;
        end
      end
      LOW: begin
        if (phase_done) state_d = HIGH;
      end
      HIGH: begin
        if (phase_done) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = HOLD;
          end else begin
            state_d   = LOW;
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      HOLD: begin
        if (phase_done) state_d = GAP;
      end
      GAP: begin
        if (phase_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they register on the same
  // edge as the state change.
  always_comb begin
    sclk_d     = SPI_CPOL;
    mosi_d     = 1'b0;
    cs_n_d     = 1'b1;
    in_ready_d = 1'b0;
    busy_d     = 1'b1;
    case (state_d)
      IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      LOW: begin
        cs_n_d = 1'b0;
        mosi_d = shift_d[0];
      end
      HIGH: begin
        sclk_d = ~SPI_CPOL;
        cs_n_d = 1'b0;
        mosi_d = mosi_q;
      end
      HOLD: begin
        // Keep the last bit on the wire through the cs_n hold time.
        cs_n_d = 1'b0;
        mosi_d = mosi_q;
      end
      default: begin
        // GAP: bus released, outputs at their idle levels.
      end
    endcase
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_word_tx.sv
// Bench for spi_word_tx: a CLK_DIV=4 instance and a CLK_DIV=1 instance share clk/rst.
// A bus monitor plays the downstream receiver and records per-cycle sclk/mosi traces.
// Traces are compared to an ideal waveform computed from the word and divider.
module tb_spi_word_tx;

  logic        clk;
  logic        rst;
  logic [15:0] in_data0, in_data1;
  logic        in_valid0, in_valid1;
  logic        in_ready0, in_ready1;
  logic        busy0, busy1;
  logic        sclk0, sclk1;
  logic        mosi0, mosi1;
  logic        cs_n0, cs_n1;

  spi_word_tx #(.DATA_BITS(16), .CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .busy(busy0), .sclk(sclk0), .mosi(mosi0), .cs_n(cs_n0)
  );

  spi_word_tx #(.DATA_BITS(16), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .busy(busy1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc [2];

  always @(posedge clk) cyc++;

  // ---------------- bus monitor / receiver model ----------------
  logic        tr_s   [2][1024];
  logic        tr_m   [2][1024];
  int          tr_len [2];
  logic        rise_m [2][64];
  int          rise_cnt [2];
  logic [15:0] rx_sh  [2];
  logic [15:0] rx_word [2][64];
  int          rx_cnt [2];
  int          hi_run [2];
  int          csh_last [2];
  logic        p_csn  [2];
  logic        p_sclk [2];
  logic        mon_s, mon_m, mon_c;

  initial begin
    for (int g = 0; g < 2; g++) begin
      tr_len[g] = 0; rise_cnt[g] = 0; rx_sh[g] = '0; rx_cnt[g] = 0;
      hi_run[g] = 0; csh_last[g] = 0; p_csn[g] = 1'b1; p_sclk[g] = 1'b0;
      acc_cyc[g] = 0;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      mon_s = (g == 0) ? sclk0 : sclk1;
      mon_m = (g == 0) ? mosi0 : mosi1;
      mon_c = (g == 0) ? cs_n0 : cs_n1;
      if (mon_c == 1'b0) begin
        if (p_csn[g]) begin
          csh_last[g] = hi_run[g];
          tr_len[g]   = 0;
          rise_cnt[g] = 0;
        end
        if (tr_len[g] < 1024) begin
          tr_s[g][tr_len[g]] = mon_s;
          tr_m[g][tr_len[g]] = mon_m;
          tr_len[g]++;
        end
        if (mon_s && !p_sclk[g]) begin
          rx_sh[g] = {mon_m, rx_sh[g][15:1]};
          if (rise_cnt[g] < 64) rise_m[g][rise_cnt[g]] = mon_m;
          rise_cnt[g]++;
        end
        hi_run[g] = 0;
      end else begin
        if (!p_csn[g]) begin
          rx_word[g][rx_cnt[g] % 64] = rx_sh[g];
          rx_cnt[g]++;
        end
        hi_run[g]++;
      end
      p_csn[g]  = mon_c;
      p_sclk[g] = mon_s;
    end
  end

  // ---------------- reference model ----------------
  // Ideal cs_n-low window: per bit, cd cycles sclk low then cd high, mosi = that
  // bit throughout; then cd cycles of hold with sclk low and the MSB held.
  function automatic bit trace_ok(input int g, input logic [15:0] w, input int cd);
    int n;
    n = (2 * 16 + 1) * cd;
    if (tr_len[g] != n) return 1'b0;
    for (int i = 0; i < n; i++) begin
      int   b;
      logic es, em;
      b = i / (2 * cd);
      if (b < 16) begin
        es = ((i % (2 * cd)) >= cd);
        em = w[b];
      end else begin
        es = 1'b0;
        em = w[15];
      end
      if (tr_s[g][i] !== es || tr_m[g][i] !== em) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int exp_latency(input int cd);
    return 2 * 16 * cd + 2 * cd;
  endfunction

  function automatic logic [15:0] last_rx(input int g);
    if (rx_cnt[g] == 0) return 16'hxxxx;
    return rx_word[g][(rx_cnt[g] - 1) % 64];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  function automatic logic rdy(input int g);
    return (g == 0) ? in_ready0 : in_ready1;
  endfunction

  task automatic drive(input int g, input logic v, input logic [15:0] d);
    if (g == 0) begin in_valid0 = v; in_data0 = d; end
    else        begin in_valid1 = v; in_data1 = d; end
  endtask

  // Waits (bounded) until in_ready is seen with in_valid already driven, then
  // lets the accept edge pass.
  task automatic wait_accept(input int g, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rdy(g) === 1'b1) begin ok = 1'b1; break; end
      nstep();
    end
    if (ok) begin
      @(posedge clk);
      nstep();
      acc_cyc[g] = cyc;
    end
  endtask

  task automatic send(input int g, input logic [15:0] w, output bit ok);
    nstep();
    drive(g, 1'b1, w);
    wait_accept(g, ok);
    drive(g, 1'b0, w);
  endtask

  task automatic wait_done(input int g, output int lat);
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      if (rdy(g) === 1'b1) begin lat = cyc - acc_cyc[g]; break; end
      nstep();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    drive(0, 1'b0, 16'h0000);
    drive(1, 1'b0, 16'h0000);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (sclk0 !== 1'b0) begin n_bad++; $display("FAIL reset_sclk: got %b want 0", sclk0); end
    n_cmp++; if (mosi0 !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", mosi0); end
    n_cmp++; if (cs_n0 !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n: got %b want 1", cs_n0); end
    n_cmp++; if (in_ready0 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_cmp++;
    if ({sclk1, mosi1, cs_n1, in_ready1, busy1} !== 5'b00110) begin
      n_bad++;
      $display("FAIL reset_div1: got %b want 00110", {sclk1, mosi1, cs_n1, in_ready1, busy1});
    end
    repeat (3) @(posedge clk);
    nstep();
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    bit          ok;
    int          lat;
    logic        edges [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    logic [15:0] want_v, got_v;
    send(0, 16'hA5C3, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_accept: got %b want 1", ok); end
    wait_done(0, lat);
    n_cmp++; if (lat != exp_latency(4)) begin n_bad++; $display("FAIL single_latency: got %0d want %0d", lat, exp_latency(4)); end
    n_cmp++; if (last_rx(0) !== 16'hA5C3) begin n_bad++; $display("FAIL single_rx: got %h want a5c3", last_rx(0)); end
    n_cmp++; if (rise_cnt[0] != 16) begin n_bad++; $display("FAIL single_edges: got %0d want 16", rise_cnt[0]); end
    n_cmp++; if (trace_ok(0, 16'hA5C3, 4) !== 1'b1) begin n_bad++; $display("FAIL single_waveform: got len %0d want %0d", tr_len[0], 33 * 4); end
    for (int i = 0; i < 16; i++) begin
      want_v[i] = edges[i];
      got_v[i]  = rise_m[0][i];
    end
    n_cmp++; if (got_v !== want_v) begin n_bad++; $display("FAIL single_edge_bits: got %b want %b", got_v, want_v); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int lat, base;
    base = rx_cnt[0];
    nstep();
    drive(0, 1'b1, 16'h0001);
    wait_accept(0, ok1);
    drive(0, 1'b1, 16'hFFFF);
    wait_accept(0, ok2);
    drive(0, 1'b0, 16'hFFFF);
    wait_done(0, lat);
    n_cmp++; if ((ok1 && ok2) !== 1'b1) begin n_bad++; $display("FAIL b2b_accepts: got %b%b want 11", ok1, ok2); end
    n_cmp++; if (rx_cnt[0] - base != 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", rx_cnt[0] - base); end
    n_cmp++; if (rx_word[0][base % 64] !== 16'h0001) begin n_bad++; $display("FAIL b2b_word0: got %h want 0001", rx_word[0][base % 64]); end
    n_cmp++; if (rx_word[0][(base + 1) % 64] !== 16'hFFFF) begin n_bad++; $display("FAIL b2b_word1: got %h want ffff", rx_word[0][(base + 1) % 64]); end
    n_cmp++; if (csh_last[0] != 4 + 1) begin n_bad++; $display("FAIL b2b_cs_gap: got %0d want 5", csh_last[0]); end
  endtask

  task automatic test_ignored();
    bit ok;
    int lat, base;
    base = rx_cnt[0];
    send(0, 16'h1234, ok);
    drive(0, 1'b1, 16'hBEEF);
    nstep();
    drive(0, 1'b0, 16'h5555);
    wait_done(0, lat);
    n_cmp++; if (last_rx(0) !== 16'h1234) begin n_bad++; $display("FAIL ignored_word: got %h want 1234", last_rx(0)); end
    repeat (40) nstep();
    n_cmp++; if (rx_cnt[0] - base != 1) begin n_bad++; $display("FAIL ignored_extra_txn: got %0d want 1", rx_cnt[0] - base); end
    n_cmp++; if ({cs_n0, in_ready0} !== 2'b11) begin n_bad++; $display("FAIL ignored_idle: got %b want 11", {cs_n0, in_ready0}); end
  endtask

  task automatic test_abort();
    bit          ok;
    int          lat;
    logic [15:0] w;
    w = 16'($urandom);
    send(0, w, ok);
    for (int i = 0; i < 400; i++) begin
      if (rise_cnt[0] >= 7) break;
      nstep();
    end
    n_cmp++; if (rise_cnt[0] != 7) begin n_bad++; $display("FAIL abort_edges: got %0d want 7", rise_cnt[0]); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({cs_n0, sclk0} !== 2'b10) begin n_bad++; $display("FAIL abort_bus: got %b want 10", {cs_n0, sclk0}); end
    n_cmp++; if ({in_ready0, busy0, mosi0} !== 3'b100) begin n_bad++; $display("FAIL abort_idle: got %b want 100", {in_ready0, busy0, mosi0}); end
    nstep();
    nstep();
    rst = 1'b0;
    send(0, 16'h00FF, ok);
    wait_done(0, lat);
    n_cmp++; if (last_rx(0) !== 16'h00FF) begin n_bad++; $display("FAIL abort_resend: got %h want 00ff", last_rx(0)); end
    n_cmp++; if (trace_ok(0, 16'h00FF, 4) !== 1'b1) begin n_bad++; $display("FAIL abort_waveform: got len %0d want %0d", tr_len[0], 33 * 4); end
  endtask

  task automatic test_clk_div1();
    bit          ok;
    int          lat;
    logic [15:0] got_v;
    send(1, 16'h8000, ok);
    wait_done(1, lat);
    n_cmp++; if (lat != exp_latency(1)) begin n_bad++; $display("FAIL div1_latency: got %0d want %0d", lat, exp_latency(1)); end
    n_cmp++; if (last_rx(1) !== 16'h8000) begin n_bad++; $display("FAIL div1_rx: got %h want 8000", last_rx(1)); end
    n_cmp++; if (trace_ok(1, 16'h8000, 1) !== 1'b1) begin n_bad++; $display("FAIL div1_waveform: got len %0d want 33", tr_len[1]); end
    for (int i = 0; i < 16; i++) got_v[i] = rise_m[1][i];
    n_cmp++; if (got_v !== 16'h8000) begin n_bad++; $display("FAIL div1_edge_bits: got %b want 1000000000000000", got_v); end
  endtask

  task automatic test_random();
    bit          ok;
    int          lat, g, cd;
    logic [15:0] w;
    for (int k = 0; k < 8; k++) begin
      g  = k % 2;
      cd = (g == 0) ? 4 : 1;
      w  = 16'($urandom);
      send(g, w, ok);
      wait_done(g, lat);
      n_cmp++; if (lat != exp_latency(cd)) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", k, lat, exp_latency(cd)); end
      n_cmp++; if (last_rx(g) !== w) begin n_bad++; $display("FAIL rand_rx[%0d]: got %h want %h", k, last_rx(g), w); end
      n_cmp++; if (trace_ok(g, w, cd) !== 1'b1) begin n_bad++; $display("FAIL rand_waveform[%0d]: got len %0d want %0d", k, tr_len[g], 33 * cd); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_ignored();
    test_abort();
    test_clk_div1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_word_tx.md
Name: spi_word_tx

Overview:
- Parallel-to-serial SPI master transmitter on the system clock.
- Accepts a DATA_BITS-wide word over a valid/ready handshake and serialises it LSB-first onto sclk/mosi/cs_n.
- Sits directly upstream of the team's SPI serial-to-parallel receiver:
  - the receiver shifts right on each sclk rising edge;
  - it copies the shifted word to its output when cs_n rises;
  - so after one transaction its output equals the word sent here.

Parameters:
- DATA_BITS, 16: bits per transaction; must match the receiver's OUTPUT_BITS; at least 2.
- CLK_DIV, 4: clk cycles per sclk half-period; at least 1. sclk frequency = clk / (2*CLK_DIV).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_BITS  word to transmit; sampled only on accept.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- busy  output  1  a transaction is in progress; equals not in_ready.
- sclk  output  1  SPI clock, mode 0: idles low, receiver samples on the rising edge.
- mosi  output  1  serial data, LSB first.
- cs_n  output  1  active-low chip select.

Behaviour:
- All outputs are registered. They take the value for the new state on the same clk edge the state changes.
- Reset (asynchronous, applied immediately):
  - state = IDLE, in_ready = 1, busy = 0;
  - sclk = 0, mosi = 0, cs_n = 1;
  - shift register, bit counter and divider counter all 0.
- Reset mid-transaction aborts it. cs_n rises asynchronously, so the downstream receiver latches a partial word. This is accepted behaviour; software must resend.
- Accept occurs when in_valid && in_ready at a clk edge. On that edge:
  - in_data is loaded into the shift register;
  - state moves to LOW; cs_n = 0; mosi = in_data[0]; in_ready = 0.
- in_valid while in_ready = 0 is ignored; in_data changes during a transaction have no effect.
- A divider counter runs 0..CLK_DIV-1. Each state except IDLE lasts exactly CLK_DIV clk cycles.
- State machine:
  - IDLE: sclk = 0, cs_n = 1. Go to LOW on accept.
  - LOW: sclk = 0, cs_n = 0, mosi = current LSB of the shift register. Then go to HIGH.
  - HIGH: sclk = 1. At the end of the phase:
    - if bit_cnt == DATA_BITS-1, go to HOLD;
    - otherwise shift right by 1, increment bit_cnt, go to LOW with mosi = new LSB.
  - HOLD: sclk = 0, cs_n = 0, mosi unchanged. Provides cs_n hold after the last rising edge. Then go to GAP.
  - GAP: cs_n = 1, sclk = 0, mosi = 0. Then go to IDLE with in_ready = 1.
- Exactly DATA_BITS sclk rising edges per transaction. mosi is stable for CLK_DIV cycles before and after each rising edge.
- Latency: in_ready returns high exactly 2*DATA_BITS*CLK_DIV + 2*CLK_DIV cycles after the accept edge (136 cycles at the defaults).
- Minimum cs_n-high time between words is CLK_DIV+1 cycles: GAP plus one IDLE accept cycle. Back-to-back transfers with in_valid held high achieve exactly this.
- Counter widths are $clog2 of the respective range (minimum 1 bit). The divider wraps at CLK_DIV-1, never at a power of two.

Decomposition:
- Shared package spi_pkg holds:
  - the state enum (IDLE, LOW, HIGH, HOLD, GAP);
  - the SPI mode constant (CPOL = 0, CPHA = 0);
  - a default word-width constant (16), shared with the receiver.
- One natural sub-module, spi_phase_timer:
  - parameter CLK_DIV;
  - inputs clk, rst, restart;
  - output phase_done, a one-cycle pulse every CLK_DIV cycles;
  - the FSM restarts it on every state change.

Test Plan:
- Reset values: assert rst mid-cycle with no clk edge -> sclk = 0, mosi = 0, cs_n = 1, in_ready = 1, busy = 0 immediately.
- Single word, CLK_DIV = 4, send 16'hA5C3:
  - mosi at the 16 sclk rising edges = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1;
  - exactly 16 rising edges; sclk high and low phases each 4 cycles;
  - a connected receiver reads out = 16'hA5C3 after cs_n rises;
  - in_ready returns high 136 cycles after accept.
- Back-to-back: in_valid held high with 16'h0001 then 16'hFFFF -> cs_n high for exactly 5 cycles between words; receiver reads 16'h0001, then 16'hFFFF.
- Ignored input: pulse in_valid with 16'h1234 while busy, then change in_data -> no extra transaction; transmitted word unchanged.
- Abort: assert rst after the 7th sclk rising edge -> cs_n = 1 and sclk = 0 at once; FSM in IDLE; the next accepted word 16'h00FF transmits correctly.
- CLK_DIV = 1, send 16'h8000 -> sclk = clk/2; mosi high only at the 16th rising edge; receiver out = 16'h8000.
